step_pulse_gen: RTL and testbench

//  Consumes the debounced push-button level and produces single-cycle step enables for the CPU core.

---
 rtl/step_pulse_pkg.sv | 11 +
 rtl/cycle_timer.sv | 22 ++
 rtl/step_pulse_gen.sv | 103 ++++++++++
 tb/tb_step_pulse_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/step_pulse_pkg.sv
// Shared types and widths for the step pulse generator.
package step_pulse_pkg;
    localparam int STATE_W = 2;
    localparam int PCNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;
endpackage

// File: rtl/cycle_timer.sv
// Clearable up-counter; done is high for the one cycle the count sits at term while enabled.
module cycle_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    assign done = en & ~clr & (cnt == term);

    // Wrapping to zero on done lets back-to-back periods run without a separate clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (clr || done)   cnt <= '0;
        else if (en)            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/step_pulse_gen.sv
// Button-to-step-enable generator for the CPU core: single step, optional auto-repeat, free run.
// Auto-repeat while held is built only when STEP_AUTOREPEAT_EN is defined.
module step_pulse_gen
    import step_pulse_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int HOLD_CYCLES   = 5_000_000,
    parameter int REPEAT_CYCLES = 1_000_000,
    parameter int RUN_DIV       = 50_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_db,
    input  logic              run_mode,
    output logic              step_pulse,
    output logic              held,
    output logic [PCNT_W-1:0] press_count
);
    state_t           state;
    logic             btn_q;
    logic             run_q;
    logic             rise;
    logic             mode_chg;
    logic             trk_en;
    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_term;

    assign rise     = btn_db & ~btn_q;
    assign mode_chg = run_mode ^ run_q;

`ifdef STEP_AUTOREPEAT_EN
    assign trk_en = (state != IDLE) & btn_db;
`else
    assign trk_en = 1'b0;
`endif

    // One timer serves run division and hold/repeat timing; idle or released step mode keeps it at zero.
    assign tmr_en   = run_mode | trk_en;
    assign tmr_clr  = mode_chg | (~run_mode & ~trk_en);
    assign tmr_term = run_mode        ? CNT_W'(RUN_DIV - 1)     :
                      (state == HOLD) ? CNT_W'(HOLD_CYCLES - 1) :
                                        CNT_W'(REPEAT_CYCLES - 1);

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            btn_q       <= 1'b1;
            run_q       <= 1'b0;
            step_pulse  <= 1'b0;
            held        <= 1'b0;
            press_count <= '0;
        end else begin
            btn_q      <= btn_db;
            run_q      <= run_mode;
            step_pulse <= 1'b0;
            if (mode_chg || run_mode) begin
                state <= IDLE;
                held  <= 1'b0;
                if (!mode_chg && tmr_done) step_pulse <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            step_pulse  <= 1'b1;
                            press_count <= press_count + 1'b1;
                            state       <= HOLD;
                            held        <= 1'b1;
                        end
                    end
                    HOLD, REPEAT: begin
                        // Release takes priority over a coincident timer terminal.
                        if (!btn_db) begin
                            state <= IDLE;
                            held  <= 1'b0;
                        end
`ifdef STEP_AUTOREPEAT_EN
                        else if (tmr_done) begin
                            step_pulse  <= 1'b1;
                            press_count <= press_count + 1'b1;
                            state       <= REPEAT;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with a cycle model driven by elapsed-cycle arithmetic.
module tb_step_pulse_gen;
    localparam int HOLD   = 8;
    localparam int REPEAT = 4;
    localparam int RUNDIV = 5;
`ifdef STEP_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_db = 1'b1;
    logic       run_mode = 1'b0;
    logic       step_pulse;
    logic       held;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;
    int win_pulses = 0;
    int win_held = 0;

    step_pulse_gen #(
        .CNT_W(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .RUN_DIV(RUNDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_db(btn_db), .run_mode(run_mode),
        .step_pulse(step_pulse), .held(held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pulses are placed by how many edges have elapsed since the rise or the run-mode entry.
    bit       m_prev_btn, m_prev_run, m_active;
    int       m_k, m_m;
    bit       exp_pulse, exp_held;
    logic [7:0] exp_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_btn = 1'b1; m_prev_run = 1'b0; m_active = 1'b0;
            m_k = 0; m_m = 0; exp_pulse = 1'b0; exp_held = 1'b0; exp_cnt = 8'd0;
        end else begin
            exp_pulse = 1'b0;
            if (run_mode != m_prev_run) begin
                m_active = 1'b0;
                m_m = 0;
            end else if (run_mode) begin
                m_m++;
                if (m_m % RUNDIV == 0) exp_pulse = 1'b1;
            end else if (m_active) begin
                if (!btn_db) m_active = 1'b0;
                else begin
                    m_k++;
                    if (AR && m_k >= HOLD && (m_k - HOLD) % REPEAT == 0) begin
                        exp_pulse = 1'b1;
                        exp_cnt++;
                    end
                end
            end else if (btn_db && !m_prev_btn) begin
                m_active = 1'b1;
                m_k = 0;
                exp_pulse = 1'b1;
                exp_cnt++;
            end
            m_prev_btn = btn_db;
            m_prev_run = run_mode;
            exp_held = m_active;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("step_pulse", int'(step_pulse), int'(exp_pulse));
            chk("held", int'(held), int'(exp_held));
            chk("press_count", int'(press_count), int'(exp_cnt));
            if (step_pulse) win_pulses++;
            if (held) win_held++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset with the button already pressed: must not fire until released and pressed again.
        tick(3);
        chk("rst_pulse", int'(step_pulse), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_count", int'(press_count), 0);
        rst_n = 1'b1;
        win_pulses = 0;
        tick(5);
        chk("held_thru_reset_pulses", win_pulses, 0);
        chk("held_thru_reset_held", int'(held), 0);

        // Short press: one pulse one cycle after the rise, held for three cycles.
        btn_db = 1'b0; tick(2);
        win_pulses = 0; win_held = 0;
        btn_db = 1'b1; tick(1);
        chk("first_pulse_latency", int'(step_pulse), 1);
        tick(1);
        chk("pulse_single_cycle", int'(step_pulse), 0);
        tick(1);
        btn_db = 1'b0; tick(3);
        chk("short_press_pulses", win_pulses, 1);
        chk("short_press_held", win_held, 3);
        chk("short_press_count", int'(press_count), 1);

        // Long hold of 20 cycles.
        win_pulses = 0;
        btn_db = 1'b1; tick(20);
        btn_db = 1'b0; tick(4);
        chk("hold20_pulses", win_pulses, AR ? 4 : 1);
        chk("hold20_count", int'(press_count), AR ? 5 : 2);

        // Release sampled on the same edge as the first repeat terminal.
        win_pulses = 0;
        btn_db = 1'b1; tick(12);
        btn_db = 1'b0; tick(3);
        chk("release_at_term_pulses", win_pulses, AR ? 2 : 1);
        chk("release_at_term_held", int'(held), 0);
        chk("release_at_term_count", int'(press_count), AR ? 7 : 3);

        // Run mode for 16 cycles with the button wiggled, then return while holding it.
        win_pulses = 0; win_held = 0;
        run_mode = 1'b1; tick(4);
        btn_db = 1'b1; tick(3);
        btn_db = 1'b0; tick(6);
        btn_db = 1'b1; tick(3);
        run_mode = 1'b0; tick(5);
        btn_db = 1'b0; tick(2);
        chk("run_pulses", win_pulses, 3);
        chk("run_held", win_held, 0);
        chk("run_count_frozen", int'(press_count), AR ? 7 : 3);

        // Reset in the middle of a held press.
        btn_db = 1'b1; tick(5);
        rst_n = 1'b0; #1;
        chk("midrst_held", int'(held), 0);
        chk("midrst_pulse", int'(step_pulse), 0);
        chk("midrst_count", int'(press_count), 0);
        btn_db = 1'b0; tick(2);
        rst_n = 1'b1; tick(2);

        // press_count wraps after 256 presses.
        for (int i = 0; i < 255; i++) begin
            btn_db = 1'b1; tick(1);
            btn_db = 1'b0; tick(1);
        end
        chk("count_255", int'(press_count), 255);
        btn_db = 1'b1; tick(1);
        btn_db = 1'b0; tick(2);
        chk("count_wrap", int'(press_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
